// File: rtl/rvfi_retire_packer.sv
// rvfi_retire_packer: collects single-issue retirement records into a FIFO and
// drains up to NRET of them per cycle onto an NRET-slot RVFI bus. Each emitted
// slot gets a monotonic 64-bit rvfi_order.
// Optional build macro RVFI_PCCHK_EN adds a sticky pc_err output. pc_err flags a
// break in the pc_rdata / pc_wdata chain between consecutive emitted records.
module rvfi_retire_packer #(
  parameter int NRET  = 1,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4,
  localparam int REC_W = ILEN + 18 + 8*XLEN + XLEN/4,
  localparam int MW    = XLEN/8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REC_W-1:0]     in_rec,
  output logic [NRET-1:0]      rvfi_valid,
  output logic [NRET*64-1:0]   rvfi_order,
  output logic [NRET*ILEN-1:0] rvfi_insn,
  output logic [NRET-1:0]      rvfi_trap,
  output logic [NRET-1:0]      rvfi_halt,
  output logic [NRET-1:0]      rvfi_intr,
  output logic [NRET*2-1:0]    rvfi_mode,
  output logic [NRET*2-1:0]    rvfi_ixl,
  output logic [NRET*5-1:0]    rvfi_rs1_addr,
  output logic [NRET*5-1:0]    rvfi_rs2_addr,
  output logic [NRET*XLEN-1:0] rvfi_rs1_rdata,
  output logic [NRET*XLEN-1:0] rvfi_rs2_rdata,
  output logic [NRET*5-1:0]    rvfi_rd_addr,
  output logic [NRET*XLEN-1:0] rvfi_rd_wdata,
  output logic [NRET*XLEN-1:0] rvfi_pc_rdata,
  output logic [NRET*XLEN-1:0] rvfi_pc_wdata,
  output logic [NRET*XLEN-1:0] rvfi_mem_addr,
  output logic [NRET*MW-1:0]   rvfi_mem_rmask,
  output logic [NRET*MW-1:0]   rvfi_mem_wmask,
  output logic [NRET*XLEN-1:0] rvfi_mem_rdata,
  output logic [NRET*XLEN-1:0] rvfi_mem_wdata,
`ifdef RVFI_PCCHK_EN
  output logic                 pc_err,
`endif
  output logic                 halted
);

  // Record field offsets, counted from the LSB (mem_wdata) upward.
  localparam int O_MWDATA = 0;
  localparam int O_MRDATA = XLEN;
  localparam int O_MWMASK = 2*XLEN;
  localparam int O_MRMASK = 2*XLEN + MW;
  localparam int O_MADDR  = 2*XLEN + 2*MW;
  localparam int O_PCW    = 3*XLEN + 2*MW;
  localparam int O_PCR    = 4*XLEN + 2*MW;
  localparam int O_RDW    = 5*XLEN + 2*MW;
  localparam int O_RDA    = 6*XLEN + 2*MW;
  localparam int O_RS2D   = O_RDA + 5;
  localparam int O_RS1D   = O_RS2D + XLEN;
  localparam int O_RS2A   = O_RS1D + XLEN;
  localparam int O_RS1A   = O_RS2A + 5;
  localparam int O_INTR   = O_RS1A + 5;
  localparam int O_HALT   = O_INTR + 1;
  localparam int O_TRAP   = O_HALT + 1;
  localparam int O_INSN   = O_TRAP + 1;

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    count_q, count_d, k;
  logic [63:0]      base_q, base_d;
  logic             halt_seen_q, halt_seen_d;
  logic             halted_q, halted_d;
  logic             push;

  logic [REC_W-1:0] slot_q [NRET];
  logic [REC_W-1:0] slot_d [NRET];
  logic [63:0]      order_q [NRET];
  logic [63:0]      order_d [NRET];
  logic [NRET-1:0]  valid_q, valid_d;

  logic [REC_W-1:0] rec;
  logic [PW-1:0]    rd_idx;

`ifdef RVFI_PCCHK_EN
  logic             lpc_v_q, lpc_v_d;
  logic             ltrap_q, ltrap_d;
  logic [XLEN-1:0]  lpc_q, lpc_d;
  logic             pc_err_q, pc_err_d;
  assign pc_err = pc_err_q;
`endif

  // Acceptance uses only registered occupancy, never the same-cycle pop.
  assign in_ready = reset && !halt_seen_q && (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;

  // Pop selection, slot packing, order assignment and pointer bookkeeping.
  always_comb begin
    k           = (count_q < CW'(NRET)) ? count_q : CW'(NRET);
    valid_d     = '0;
    halted_d    = halted_q;
    halt_seen_d = halt_seen_q;
    rec         = '0;
    rd_idx      = '0;
`ifdef RVFI_PCCHK_EN
    lpc_v_d  = lpc_v_q;
    lpc_d    = lpc_q;
    ltrap_d  = ltrap_q;
    pc_err_d = pc_err_q;
`endif
    for (int i = 0; i < NRET; i++) begin
      slot_d[i]  = '0;
      order_d[i] = '0;
      rd_idx     = PW'((int'(rd_q) + i) % DEPTH);
      rec        = mem_q[rd_idx];
      if (CW'(i) < k) begin
        // x0 writes are architecturally invisible, so present them as zero.
        if (rec[O_RDA +: 5] == 5'd0) rec[O_RDW +: XLEN] = '0;
        slot_d[i]  = rec;
        order_d[i] = base_q + 64'(i);
        valid_d[i] = 1'b1;
        if (rec[O_HALT]) halted_d = 1'b1;
`ifdef RVFI_PCCHK_EN
        if (lpc_v_d && (rec[O_PCR +: XLEN] != lpc_d) && !ltrap_d) pc_err_d = 1'b1;
        lpc_v_d = 1'b1;
        lpc_d   = rec[O_PCW +: XLEN];
        ltrap_d = rec[O_TRAP];
`endif
      end
    end
    if (push && in_rec[O_HALT]) halt_seen_d = 1'b1;
    count_d = count_q + CW'(push) - k;
    rd_d    = PW'((int'(rd_q) + int'(k)) % DEPTH);
    wr_d    = push ? PW'((int'(wr_q) + 1) % DEPTH) : wr_q;
    base_d  = base_q + 64'(k);
  end

  // FIFO storage holds data only; occupancy lives in count_q.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= in_rec;
  end

  // Control and registered RVFI slots; reset drops buffered records unemitted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      base_q      <= '0;
      halt_seen_q <= 1'b0;
      halted_q    <= 1'b0;
      valid_q     <= '0;
      for (int i = 0; i < NRET; i++) begin
        slot_q[i]  <= '0;
        order_q[i] <= '0;
      end
`ifdef RVFI_PCCHK_EN
      lpc_v_q  <= 1'b0;
      lpc_q    <= '0;
      ltrap_q  <= 1'b0;
      pc_err_q <= 1'b0;
`endif
    end else begin
      count_q     <= count_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      base_q      <= base_d;
      halt_seen_q <= halt_seen_d;
      halted_q    <= halted_d;
      valid_q     <= valid_d;
      for (int i = 0; i < NRET; i++) begin
        slot_q[i]  <= slot_d[i];
        order_q[i] <= order_d[i];
      end
`ifdef RVFI_PCCHK_EN
      lpc_v_q  <= lpc_v_d;
      lpc_q    <= lpc_d;
      ltrap_q  <= ltrap_d;
      pc_err_q <= pc_err_d;
`endif
    end
  end

  assign rvfi_valid = valid_q;
  assign halted     = halted_q;

  for (genvar g = 0; g < NRET; g++) begin : g_slot
    assign rvfi_order[g*64 +: 64]        = order_q[g];
    assign rvfi_insn[g*ILEN +: ILEN]     = slot_q[g][O_INSN +: ILEN];
    assign rvfi_trap[g]                  = slot_q[g][O_TRAP];
    assign rvfi_halt[g]                  = slot_q[g][O_HALT];
    assign rvfi_intr[g]                  = slot_q[g][O_INTR];
    assign rvfi_mode[g*2 +: 2]           = 2'd3;
    assign rvfi_ixl[g*2 +: 2]            = (XLEN == 64) ? 2'd2 : 2'd1;
    assign rvfi_rs1_addr[g*5 +: 5]       = slot_q[g][O_RS1A +: 5];
    assign rvfi_rs2_addr[g*5 +: 5]       = slot_q[g][O_RS2A +: 5];
    assign rvfi_rs1_rdata[g*XLEN +: XLEN] = slot_q[g][O_RS1D +: XLEN];
    assign rvfi_rs2_rdata[g*XLEN +: XLEN] = slot_q[g][O_RS2D +: XLEN];
    assign rvfi_rd_addr[g*5 +: 5]        = slot_q[g][O_RDA +: 5];
    assign rvfi_rd_wdata[g*XLEN +: XLEN] = slot_q[g][O_RDW +: XLEN];
    assign rvfi_pc_rdata[g*XLEN +: XLEN] = slot_q[g][O_PCR +: XLEN];
    assign rvfi_pc_wdata[g*XLEN +: XLEN] = slot_q[g][O_PCW +: XLEN];
    assign rvfi_mem_addr[g*XLEN +: XLEN] = slot_q[g][O_MADDR +: XLEN];
    assign rvfi_mem_rmask[g*MW +: MW]    = slot_q[g][O_MRMASK +: MW];
    assign rvfi_mem_wmask[g*MW +: MW]    = slot_q[g][O_MWMASK +: MW];
    assign rvfi_mem_rdata[g*XLEN +: XLEN] = slot_q[g][O_MRDATA +: XLEN];
    assign rvfi_mem_wdata[g*XLEN +: XLEN] = slot_q[g][O_MWDATA +: XLEN];
  end

endmodule

// File: tb/tb_rvfi_retire_packer.sv
// Randomized bench for rvfi_retire_packer against a queue-based reference model.
module tb_rvfi_retire_packer;
  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam int MW    = XLEN/8;
  localparam int REC_W = ILEN + 18 + 8*XLEN + XLEN/4;

  typedef struct {
    logic [ILEN-1:0] insn;
    logic            trap, halt, intr;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [XLEN-1:0] rs1_rdata, rs2_rdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata, pc_rdata, pc_wdata, mem_addr;
    logic [MW-1:0]   mem_rmask, mem_wmask;
    logic [XLEN-1:0] mem_rdata, mem_wdata;
  } rec_t;

  logic clock, reset, in_valid, in_ready, halted;
  logic [REC_W-1:0] in_rec;
  logic [NRET-1:0] rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr;
  logic [NRET*64-1:0] rvfi_order;
  logic [NRET*ILEN-1:0] rvfi_insn;
  logic [NRET*2-1:0] rvfi_mode, rvfi_ixl;
  logic [NRET*5-1:0] rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [NRET*XLEN-1:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata;
  logic [NRET*XLEN-1:0] rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
  logic [NRET*MW-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
`ifdef RVFI_PCCHK_EN
  logic pc_err;
`endif

  rvfi_retire_packer #(.NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_rec(in_rec),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
`ifdef RVFI_PCCHK_EN
    .pc_err(pc_err),
`endif
    .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model state.
  rec_t        q[$];
  logic [63:0] order_m;
  bit          hs_m, halted_m;
  bit          lpc_v_m, ltrap_m, pcerr_m;
  logic [XLEN-1:0] lpc_m;

  logic [NRET-1:0] e_valid, e_trap, e_halt, e_intr;
  logic [NRET*64-1:0] e_order;
  logic [NRET*ILEN-1:0] e_insn;
  logic [NRET*5-1:0] e_rs1a, e_rs2a, e_rda;
  logic [NRET*XLEN-1:0] e_rs1d, e_rs2d, e_rdw, e_pcr, e_pcw, e_maddr, e_mrd, e_mwd;
  logic [NRET*MW-1:0] e_rm, e_wm;

  function automatic logic [REC_W-1:0] pack(input rec_t r);
    return {r.insn, r.trap, r.halt, r.intr, r.rs1_addr, r.rs2_addr, r.rs1_rdata, r.rs2_rdata,
            r.rd_addr, r.rd_wdata, r.pc_rdata, r.pc_wdata, r.mem_addr, r.mem_rmask,
            r.mem_wmask, r.mem_rdata, r.mem_wdata};
  endfunction

  function automatic rec_t rand_rec(input logic [XLEN-1:0] pc);
    rec_t r;
    r.insn      = $urandom;
    r.trap      = ($urandom % 8) == 0;
    r.halt      = ($urandom % 60) == 0;
    r.intr      = ($urandom % 8) == 0;
    r.rs1_addr  = 5'($urandom);
    r.rs2_addr  = 5'($urandom);
    r.rs1_rdata = $urandom;
    r.rs2_rdata = $urandom;
    r.rd_addr   = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
    r.rd_wdata  = $urandom;
    r.pc_rdata  = (($urandom % 10) == 0) ? $urandom : pc;
    r.pc_wdata  = (($urandom % 6) == 0) ? $urandom : r.pc_rdata + 4;
    r.mem_addr  = $urandom;
    r.mem_rmask = MW'($urandom);
    r.mem_wmask = MW'($urandom);
    r.mem_rdata = $urandom;
    r.mem_wdata = $urandom;
    return r;
  endfunction

  function automatic rec_t mk_rec(input logic [XLEN-1:0] pcr, input logic [XLEN-1:0] pcw,
                                  input logic [4:0] rd, input logic [XLEN-1:0] rdw,
                                  input bit trap, input bit halt);
    rec_t r;
    r = rand_rec(pcr);
    r.pc_rdata = pcr; r.pc_wdata = pcw; r.rd_addr = rd; r.rd_wdata = rdw;
    r.trap = trap; r.halt = halt;
    return r;
  endfunction

  // One clock cycle: drive inputs, advance the model, then compare outputs.
  task automatic step(input bit rst_v, input bit vld, input rec_t r);
    bit   exp_ready;
    int   k;
    rec_t g;
    @(negedge clock);
    reset = rst_v; in_valid = vld; in_rec = pack(r);
    #1;
    exp_ready = rst_v && !hs_m && (q.size() < DEPTH);
    check("in_ready", in_ready, exp_ready);
    e_valid = '0; e_trap = '0; e_halt = '0; e_intr = '0; e_order = '0; e_insn = '0;
    e_rs1a = '0; e_rs2a = '0; e_rda = '0; e_rs1d = '0; e_rs2d = '0; e_rdw = '0;
    e_pcr = '0; e_pcw = '0; e_maddr = '0; e_mrd = '0; e_mwd = '0; e_rm = '0; e_wm = '0;
    if (!rst_v) begin
      q.delete(); order_m = '0; hs_m = 0; halted_m = 0;
      lpc_v_m = 0; ltrap_m = 0; pcerr_m = 0; lpc_m = '0;
    end else begin
      k = (q.size() < NRET) ? q.size() : NRET;
      for (int i = 0; i < k; i++) begin
        g = q.pop_front();
        e_valid[i] = 1'b1;
        e_order[i*64 +: 64] = order_m + 64'(i);
        e_insn[i*ILEN +: ILEN] = g.insn;
        e_trap[i] = g.trap; e_halt[i] = g.halt; e_intr[i] = g.intr;
        e_rs1a[i*5 +: 5] = g.rs1_addr; e_rs2a[i*5 +: 5] = g.rs2_addr; e_rda[i*5 +: 5] = g.rd_addr;
        e_rs1d[i*XLEN +: XLEN] = g.rs1_rdata; e_rs2d[i*XLEN +: XLEN] = g.rs2_rdata;
        e_rdw[i*XLEN +: XLEN] = (g.rd_addr == 5'd0) ? '0 : g.rd_wdata;
        e_pcr[i*XLEN +: XLEN] = g.pc_rdata; e_pcw[i*XLEN +: XLEN] = g.pc_wdata;
        e_maddr[i*XLEN +: XLEN] = g.mem_addr;
        e_mrd[i*XLEN +: XLEN] = g.mem_rdata; e_mwd[i*XLEN +: XLEN] = g.mem_wdata;
        e_rm[i*MW +: MW] = g.mem_rmask; e_wm[i*MW +: MW] = g.mem_wmask;
        if (g.halt) halted_m = 1;
        if (lpc_v_m && g.pc_rdata != lpc_m && !ltrap_m) pcerr_m = 1;
        lpc_v_m = 1; lpc_m = g.pc_wdata; ltrap_m = g.trap;
      end
      order_m = order_m + 64'(k);
      if (vld && exp_ready) begin
        q.push_back(r);
        if (r.halt) hs_m = 1;
      end
    end
    @(posedge clock);
    #1;
    check("valid", rvfi_valid, e_valid);
    check("order", rvfi_order, e_order);
    check("insn", rvfi_insn, e_insn);
    check("trap_halt_intr", {rvfi_trap, rvfi_halt, rvfi_intr}, {e_trap, e_halt, e_intr});
    check("rs_addr", {rvfi_rs1_addr, rvfi_rs2_addr}, {e_rs1a, e_rs2a});
    check("rs_rdata", {rvfi_rs1_rdata, rvfi_rs2_rdata}, {e_rs1d, e_rs2d});
    check("rd_addr", rvfi_rd_addr, e_rda);
    check("rd_wdata", rvfi_rd_wdata, e_rdw);
    check("pc", {rvfi_pc_rdata, rvfi_pc_wdata}, {e_pcr, e_pcw});
    check("mem_addr", rvfi_mem_addr, e_maddr);
    check("mem_data", {rvfi_mem_rdata, rvfi_mem_wdata}, {e_mrd, e_mwd});
    check("mem_mask", {rvfi_mem_rmask, rvfi_mem_wmask}, {e_rm, e_wm});
    check("mode_ixl", {rvfi_mode, rvfi_ixl}, {{NRET{2'd3}}, {NRET{2'd1}}});
    check("halted", halted, halted_m);
`ifdef RVFI_PCCHK_EN
    check("pc_err", pc_err, pcerr_m);
`endif
  endtask

  rec_t            r0, r;
  logic [XLEN-1:0] gpc;
  bit              v;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_rec = '0;
    order_m = '0; hs_m = 0; halted_m = 0; lpc_v_m = 0; ltrap_m = 0; pcerr_m = 0; lpc_m = '0;
    r0 = mk_rec('0, '0, 5'd0, '0, 0, 0);

    // Reset for two cycles, then idle.
    step(0, 0, r0); step(0, 0, r0);
    step(1, 0, r0); step(1, 0, r0);

    // Back-to-back pc chain 0 -> 4 -> 8, including an x0 write with junk data.
    step(1, 1, mk_rec(32'h0, 32'h4, 5'd3, 32'h1111_2222, 0, 0));
    step(1, 1, mk_rec(32'h4, 32'h8, 5'd0, 32'hDEAD_BEEF, 0, 0));
    step(1, 1, mk_rec(32'h8, 32'hC, 5'd7, 32'h3333_4444, 0, 0));
    step(1, 0, r0); step(1, 0, r0);

    // Randomized traffic with occasional resets and halts.
    gpc = 32'hC;
    for (int c = 0; c < 2500; c++) begin
      r = rand_rec(gpc);
      if ((hs_m && ($urandom % 16) == 0) || ($urandom % 300) == 0) begin
        step(0, 1, r);
      end else begin
        v = ($urandom % 4) != 0;
        step(1, v, r);
        if (v) gpc = r.pc_wdata;
      end
    end

    // Halt: no further acceptance, halted after emission, cleared by reset.
    step(0, 0, r0); step(0, 0, r0);
    step(1, 1, mk_rec(32'h100, 32'h104, 5'd1, 32'h5, 0, 1));
    for (int i = 0; i < 4; i++) step(1, 1, mk_rec(32'h104, 32'h108, 5'd2, 32'h6, 0, 0));
    step(0, 0, r0);
    step(1, 1, mk_rec(32'h200, 32'h204, 5'd4, 32'h7, 0, 0));
    step(1, 0, r0);

    // pc chain break, without and with a trap on the record before the jump.
    step(0, 0, r0);
    step(1, 1, mk_rec(32'h0, 32'h4, 5'd1, 32'h1, 0, 0));
    step(1, 1, mk_rec(32'h8, 32'hC, 5'd1, 32'h1, 0, 0));
    step(1, 0, r0); step(1, 0, r0);
    step(0, 0, r0);
    step(1, 1, mk_rec(32'h0, 32'h4, 5'd1, 32'h1, 1, 0));
    step(1, 1, mk_rec(32'h8, 32'hC, 5'd1, 32'h1, 0, 0));
    step(1, 0, r0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
